// File: rtl/line_ram_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : line_ram_scheduler
// Description : Sequencer for a five-line-RAM vertical compression datapath.
//               Rotates the RAM that receives the incoming line while the
//               other RAMs are read at the same pixel address. Produces
//               per-RAM write/read strobes, shared addresses, a rotation
//               phase index, a buffered-line count and a sticky line-length
//               error flag.
// Ports       : clk_in          - sole clock, rising edge
//               rst             - synchronous active-high reset
//               enable          - low freezes state, strobes forced to 0
//               frame_start     - pulse, restarts the rotation
//               newline         - pulse, ends the current line
//               pix_valid       - one input pixel present this cycle
//               ram_wren        - one-hot write strobe per RAM
//               wr_addr         - shared write address
//               ram_rden        - read strobes (all RAMs except the writer)
//               rd_addr         - shared read address
//               phase           - index of the RAM currently written
//               lines_buffered  - complete lines this frame, saturating
//               out_valid       - RAM read data valid for averaging stage
//               len_err         - sticky line-length error
// Revision    : 1.0 - initial release
// ============================================================================
module line_ram_scheduler #(
    parameter int NUM_RAMS    = 5,
    parameter int ADDR_W      = 11,
    parameter int LINE_LEN    = 1920,
    parameter int PRIME_LINES = 3
) (
    input  logic                clk_in,
    input  logic                rst,
    input  logic                enable,
    input  logic                frame_start,
    input  logic                newline,
    input  logic                pix_valid,
    output logic [NUM_RAMS-1:0] ram_wren,
    output logic [ADDR_W-1:0]   wr_addr,
    output logic [NUM_RAMS-1:0] ram_rden,
    output logic [ADDR_W-1:0]   rd_addr,
    output logic [2:0]          phase,
    output logic [2:0]          lines_buffered,
    output logic                out_valid,
    output logic                len_err
);

    localparam logic [2:0]      c_MAX_PTR   = 3'(NUM_RAMS - 1);
    localparam logic [2:0]      c_MAX_LINES = 3'(NUM_RAMS - 1);
    localparam logic [2:0]      c_PRIME     = 3'(PRIME_LINES);
    // One extra bit so a full line (LINE_LEN == 2**ADDR_W) is representable.
    localparam logic [ADDR_W:0] c_LINE_LEN  = (ADDR_W + 1)'(LINE_LEN);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PRIME = 2'd1,
        ST_RUN   = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [2:0]          r_wr_ptr,   w_wr_ptr_nxt;
    logic [ADDR_W:0]     r_pix_cnt,  w_pix_cnt_nxt;
    logic [ADDR_W:0]     w_cnt_eff;
    logic [2:0]          r_lines,    w_lines_nxt;
    logic                r_len_err,  w_len_err_nxt;
    logic [NUM_RAMS-1:0] r_ram_wren, w_wren_nxt;
    logic [NUM_RAMS-1:0] r_ram_rden, w_rden_nxt;
    logic [ADDR_W-1:0]   r_wr_addr,  w_wr_addr_nxt;
    logic [ADDR_W-1:0]   r_rd_addr,  w_rd_addr_nxt;
    logic                r_out_valid;
    logic [NUM_RAMS-1:0] w_onehot;

    assign w_onehot = NUM_RAMS'(1) << r_wr_ptr;

    always_ff @(posedge clk_in) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_wr_ptr_nxt  = r_wr_ptr;
        w_pix_cnt_nxt = r_pix_cnt;
        w_cnt_eff     = r_pix_cnt;
        w_lines_nxt   = r_lines;
        w_len_err_nxt = r_len_err;
        w_wren_nxt    = '0;
        w_rden_nxt    = '0;
        w_wr_addr_nxt = r_wr_addr;
        w_rd_addr_nxt = r_rd_addr;

        if (enable) begin
            if (frame_start) begin
                // Restart wins over any pixel/newline in the same cycle.
                w_state_nxt   = ST_PRIME;
                w_wr_ptr_nxt  = '0;
                w_pix_cnt_nxt = '0;
                w_lines_nxt   = '0;
                w_len_err_nxt = 1'b0;
            end else if (r_state != ST_IDLE) begin
                if (pix_valid) begin
                    if (r_pix_cnt < c_LINE_LEN) begin
                        w_wren_nxt    = w_onehot;
                        w_wr_addr_nxt = r_pix_cnt[ADDR_W-1:0];
                        if (r_state == ST_RUN) begin
                            w_rden_nxt    = ~w_onehot;
                            w_rd_addr_nxt = r_pix_cnt[ADDR_W-1:0];
                        end
                        w_cnt_eff = r_pix_cnt + 1'b1;
                    end else begin
                        w_len_err_nxt = 1'b1;
                    end
                end

                if (newline) begin
                    // Length check includes a pixel arriving with newline.
                    if (w_cnt_eff != c_LINE_LEN) begin
                        w_len_err_nxt = 1'b1;
                    end
                    w_wr_ptr_nxt  = (r_wr_ptr == c_MAX_PTR) ? 3'd0 : r_wr_ptr + 3'd1;
                    w_pix_cnt_nxt = '0;
                    w_lines_nxt   = (r_lines == c_MAX_LINES) ? r_lines : r_lines + 3'd1;
                    if ((r_state == ST_PRIME) && (r_lines + 3'd1 == c_PRIME)) begin
                        w_state_nxt = ST_RUN;
                    end
                end else begin
                    w_pix_cnt_nxt = w_cnt_eff;
                end
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst) begin
            r_wr_ptr    <= '0;
            r_pix_cnt   <= '0;
            r_lines     <= '0;
            r_len_err   <= 1'b0;
            r_ram_wren  <= '0;
            r_ram_rden  <= '0;
            r_wr_addr   <= '0;
            r_rd_addr   <= '0;
            r_out_valid <= 1'b0;
        end else begin
            r_wr_ptr    <= w_wr_ptr_nxt;
            r_pix_cnt   <= w_pix_cnt_nxt;
            r_lines     <= w_lines_nxt;
            r_len_err   <= w_len_err_nxt;
            r_ram_wren  <= w_wren_nxt;
            r_ram_rden  <= w_rden_nxt;
            r_wr_addr   <= w_wr_addr_nxt;
            r_rd_addr   <= w_rd_addr_nxt;
            // RAM read latency is one cycle behind the read strobe.
            r_out_valid <= |r_ram_rden;
        end
    end

    assign ram_wren       = r_ram_wren;
    assign wr_addr        = r_wr_addr;
    assign ram_rden       = r_ram_rden;
    assign rd_addr        = r_rd_addr;
    assign phase          = r_wr_ptr;
    assign lines_buffered = r_lines;
    assign out_valid      = r_out_valid;
    assign len_err        = r_len_err;

endmodule
`default_nettype wire

// File: doc/line_ram_scheduler.md
# line_ram_scheduler

Single-clock sequencer for the five-line-RAM vertical compression datapath. Rotates which RAM_2_ports instance is written with the incoming line while the other four are read. Generates per-RAM write/read strobes, shared pixel addresses, a rotation phase index and sticky line-length error flags. Sits between the pixel source (pix_valid/newline/frame_start) and the line RAM bank plus averaging logic.

## Interface
- NUM_RAMS, 5, number of line RAMs in rotation (fixed at 5; phase is 3 bits)
- ADDR_W, 11, pixel address width, equal to RAM_2_ports address width
- LINE_LEN, 1920, active pixels per line; must be ≤ 2^ADDR_W
- PRIME_LINES, 3, complete lines buffered before reads start; 1..NUM_RAMS-1
- clk_in  in  1  sole clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- enable  in  1  global enable; low freezes all state and forces strobes to 0
- frame_start  in  1  single-cycle pulse; restarts the rotation
- newline  in  1  single-cycle pulse, clk_in domain; ends the current line
- pix_valid  in  1  one input pixel present this cycle
- ram_wren  out  NUM_RAMS  one-hot write strobe, bit k = RAM k
- wr_addr  out  ADDR_W  write address shared by all RAMs
- ram_rden  out  NUM_RAMS  read strobes, = ~one-hot(wr_ptr) when reading
- rd_addr  out  ADDR_W  read address shared by all RAMs
- phase  out  3  current write RAM index wr_ptr, 0..4
- lines_buffered  out  3  complete lines stored this frame, saturating at 4
- out_valid  out  1  RAM q data valid for the averaging stage
- len_err  out  1  sticky: a line ended with pixel count ≠ LINE_LEN, or overflowed

## Operation
- States: IDLE, PRIME, RUN. Reset → IDLE.
- Any state, enable=1, frame_start=1 → PRIME.
  - Also clears wr_ptr, pix_cnt, lines_buffered, len_err.
  - frame_start has priority over newline and pix_valid in the same cycle; that pixel is dropped.
- IDLE: pix_valid and newline are ignored; all strobes are 0.
- PRIME/RUN, pix_valid=1:
  - If pix_cnt < LINE_LEN: ram_wren = one-hot(wr_ptr), wr_addr = pix_cnt, pix_cnt += 1.
  - If pix_cnt = LINE_LEN: write is suppressed and len_err is set.
- RUN, pix_valid=1 with pix_cnt < LINE_LEN: ram_rden = ~one-hot(wr_ptr), rd_addr = pix_cnt. This is the same address as the write.
- newline in PRIME/RUN:
  - If pix_cnt ≠ LINE_LEN, len_err is set. This includes zero-pixel lines, which still advance the rotation.
  - wr_ptr = (wr_ptr==4) ? 0 : wr_ptr+1; pix_cnt = 0; lines_buffered += 1, saturating at 4.
  - PRIME → RUN when the incremented lines_buffered equals PRIME_LINES.
- newline and pix_valid in the same cycle: the pixel is written to the ending line at the current pix_cnt first, then the line advances. The len_err check uses the count including that pixel.
- enable=0: state, counters and flags hold; ram_wren/ram_rden = 0 next cycle; newline/frame_start/pix_valid are ignored (not queued).
- Arithmetic: pix_cnt is ADDR_W+1 bits internally to represent LINE_LEN without wrap; wr_addr/rd_addr carry the low ADDR_W bits.

## Timing
- All outputs are registered.
- ram_wren/wr_addr/ram_rden/rd_addr are valid 1 cycle after the qualifying pix_valid edge.
- RAM read latency is 1 cycle, so out_valid = ram_rden != 0 delayed by 1: 2 cycles after pix_valid.
- phase and lines_buffered update 1 cycle after newline/frame_start.
- Reset values: ram_wren=0, ram_rden=0, wr_addr=0, rd_addr=0, phase=0, lines_buffered=0, out_valid=0, len_err=0.
- rst asserted mid-line takes effect next edge: all outputs go to reset values and the in-flight out_valid is cancelled.
- Back-to-back pix_valid sustains one write (and in RUN one read) per cycle; no bubbles.
- Wrap: phase 4 → 0 on newline; no other wrap permitted.

## Test plan
Bench parameters for all cases: LINE_LEN=8, PRIME_LINES=3.
- **Priming and rotation:** frame_start, then 3 lines of 8 pixels each followed by newline.
  - ram_wren = 00001, 00010, 00100 per line; wr_addr 0..7 each line.
  - ram_rden stays 0 throughout; lines_buffered reaches 3; state RUN.
- **Steady run:** 4th line of 8 pixels.
  - ram_wren = 01000, ram_rden = 10111, rd_addr = wr_addr = 0..7.
  - out_valid high for 8 cycles starting 2 cycles after the first pix_valid.
  - After 2 more lines, phase goes 4 → 0 and lines_buffered holds at 4.
- **Errors:** a short line of 5 pixels + newline sets len_err and phase still advances.
  - A 10-pixel line suppresses writes on pixels 9–10 and sets len_err.
  - The next frame_start clears len_err.
- **Simultaneous events:** pix_valid with newline on the 8th pixel → write at addr 7, no len_err.
  - frame_start with newline and pix_valid in one cycle → phase 0, lines_buffered 0, no strobe that cycle.
- **Enable freeze:** drop enable mid-line at pix_cnt=4 for 3 cycles while driving pix_valid and newline.
  - Strobes are 0 and phase is unchanged.
  - On resume, writing continues at wr_addr 4.
- **Reset mid-operation:** rst during RUN at pix_cnt=3.
  - Every output equals its reset value the next cycle.
  - pix_valid is ignored until the next frame_start.
